// File: rtl/fifo_fwft_adapter_if.sv
// Handshake bundle for the FWFT read adapter: the upstream standard-FIFO read
// port on one side and the FWFT consumer port plus debug status on the other.
interface fifo_fwft_adapter_if #(
  parameter int DATA_WIDTH = 36,
  parameter int CNT_WIDTH  = 32
);
  logic [DATA_WIDTH-1:0] fifo_dout;
  logic                  fifo_empty;
  logic                  fifo_rd_en;
  logic                  rd_en;
  logic [DATA_WIDTH-1:0] dout;
  logic                  empty;
  logic [CNT_WIDTH-1:0]  rd_count;
  logic                  underflow;

  // Adapter side.
  modport slave (
    input  fifo_dout, fifo_empty, rd_en,
    output fifo_rd_en, dout, empty, rd_count, underflow
  );

  // Environment side: upstream FIFO plus FWFT consumer.
  modport master (
    output fifo_dout, fifo_empty, rd_en,
    input  fifo_rd_en, dout, empty, rd_count, underflow
  );
endinterface

// File: rtl/fifo_fwft_adapter.sv
// Converts a 1-cycle-latency standard FIFO read port into a first-word-fall-
// through port. A 2-entry register buffer plus a one-deep read-ahead credit
// keeps one word per clock flowing without bubbles; dout is a pure register
// mux, so there is no combinational path from fifo_dout to the consumer.
module fifo_fwft_adapter #(
  parameter int DATA_WIDTH = 36,
  parameter int CNT_WIDTH  = 32
) (
  input logic                 rd_clk,
  input logic                 rst,
  fifo_fwft_adapter_if.slave  bus
);

  // Words held plus the word on its way, after this cycle's pop. Because a
  // pop needs count >= 1 this never goes negative; 3 bits hold the illegal
  // value 3 so it cannot alias to a small occupancy.
  function automatic logic [2:0] occupancy_next(input logic [1:0] count,
                                                 input logic       inflight,
                                                 input logic       pop);
    return {1'b0, count} + {2'b00, inflight} - {2'b00, pop};
  endfunction

  logic [DATA_WIDTH-1:0] buf_q [2];
  logic                  head_q;
  logic                  tail_q;
  logic [1:0]            count_q;
  logic                  vld_p1;       // read issued last cycle: word on fifo_dout now
  logic [CNT_WIDTH-1:0]  rd_count_q;
  logic                  underflow_q;

  logic                  empty_w;
  logic                  pop;
  logic [2:0]            occ_next;

  assign empty_w  = (count_q == 2'd0);
  assign pop      = bus.rd_en & ~empty_w;
  assign occ_next = occupancy_next(count_q, vld_p1, pop);

  // Only read ahead while the buffer can absorb the word one cycle later.
  assign bus.fifo_rd_en = ~rst & ~bus.fifo_empty & (occ_next < 3'd2);

  assign bus.dout      = buf_q[head_q];
  assign bus.empty     = empty_w;
  assign bus.rd_count  = rd_count_q;
  assign bus.underflow = underflow_q;

  // ---- stage p1: capture the word returned by last cycle's read ----
  // Store the arriving upstream word at the tail slot.
  always_ff @(posedge rd_clk) begin
    if (rst) begin
      buf_q[0] <= '0;
      buf_q[1] <= '0;
    end else if (vld_p1) begin
      buf_q[tail_q] <= bus.fifo_dout;
    end
  end

  // Track read credit, buffer pointers and occupancy.
  always_ff @(posedge rd_clk) begin
    if (rst) begin
      vld_p1  <= 1'b0;
      head_q  <= 1'b0;
      tail_q  <= 1'b0;
      count_q <= 2'd0;
    end else begin
      vld_p1  <= bus.fifo_rd_en;
      count_q <= occ_next[1:0];
      if (vld_p1) begin
        tail_q <= ~tail_q;
      end
      if (pop) begin
        head_q <= ~head_q;
      end
    end
  end

  // ---- stage p2: consumer-side debug status ----
  // Count accepted pops (wrapping) and latch any read attempted while empty.
  always_ff @(posedge rd_clk) begin
    if (rst) begin
      rd_count_q  <= '0;
      underflow_q <= 1'b0;
    end else begin
      if (pop) begin
        rd_count_q <= rd_count_q + CNT_WIDTH'(1);
      end
      if (bus.rd_en & empty_w) begin
        underflow_q <= 1'b1;
      end
    end
  end

endmodule
